ip4_rtl_axi_arb: RTL

IP4_RTL_AXI_ARB -- requirements
Module: ip4_rtl_axi_arb

---
 rtl/ip4_rtl_axi_arb.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/ip4_rtl_axi_arb.sv
// ip4_rtl_axi_arb: round-robin arbiter of per-channel read-burst FIFOs onto one AXI AR/R port,
// with per-channel outstanding-burst limits and combinational R routing by id.
module ip4_rtl_axi_arb #(
    parameter int NCH = 4,
    parameter int AW = 32,
    parameter int DW = 64,
    parameter int DEPTH = 4,
    parameter int MAX_OUT = 8,
    localparam int IDW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH-1:0]    ch_req_valid,
    output logic [NCH-1:0]    ch_req_ready,
    input  logic [NCH*AW-1:0] ch_req_addr,
    input  logic [NCH*8-1:0]  ch_req_len,
    output logic              ar_valid,
    input  logic              ar_ready,
    output logic [AW-1:0]     ar_addr,
    output logic [7:0]        ar_len,
    output logic [IDW-1:0]    ar_id,
    input  logic              r_valid,
    output logic              r_ready,
    input  logic [DW-1:0]     r_data,
    input  logic [IDW-1:0]    r_id,
    input  logic              r_last,
    output logic [NCH-1:0]    ch_rsp_valid,
    input  logic [NCH-1:0]    ch_rsp_ready,
    output logic [DW-1:0]     ch_rsp_data,
    output logic              ch_rsp_last,
    output logic              busy,
    output logic              err_rid
);
    localparam int PW = $clog2(DEPTH) + 1;
    localparam int EW = AW + 8;

    logic [EW-1:0]  mem_q [NCH][DEPTH];
    logic [PW-1:0]  wptr_q [NCH], wptr_d [NCH], rptr_q [NCH], rptr_d [NCH];
    logic [7:0]     cnt_q [NCH], cnt_d [NCH];
    logic [NCH-1:0] empty, full, push, pop, elig;
    logic [IDW-1:0] rr_q, rr_d, win, ar_id_q, ar_id_d;
    logic [AW-1:0]  ar_addr_q, ar_addr_d;
    logic [7:0]     ar_len_q, ar_len_d;
    logic [EW-1:0]  head;
    logic           ar_valid_q, ar_valid_d, err_q, err_d;
    logic           found, load, ar_hs, r_hs, rid_ok, cnt_nz;

    // The burst sitting in the AR stage counts against its channel's limit.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            empty[i] = wptr_q[i] == rptr_q[i];
            full[i]  = (wptr_q[i] - rptr_q[i]) == PW'(DEPTH);
            push[i]  = ch_req_valid[i] && !full[i];
            elig[i]  = !empty[i] && (({1'b0, cnt_q[i]} + {8'd0, ar_valid_q && (ar_id_q == IDW'(i))}) < 9'(MAX_OUT));
        end
    end

    always_comb begin
        found = 1'b0;
        win   = '0;
        head  = '0;
        for (int i = 0; i < NCH; i++) begin
            if (!found && elig[i] && (IDW'(i) >= rr_q)) begin
                found = 1'b1;
                win   = IDW'(i);
                head  = mem_q[i][rptr_q[i][PW-2:0]];
            end
        end
        for (int i = 0; i < NCH; i++) begin
            if (!found && elig[i]) begin
                found = 1'b1;
                win   = IDW'(i);
                head  = mem_q[i][rptr_q[i][PW-2:0]];
            end
        end
        load       = found && (!ar_valid_q || ar_ready);
        ar_hs      = ar_valid_q && ar_ready;
        rr_d       = !load ? rr_q : (win == IDW'(NCH - 1)) ? '0 : win + 1'b1;
        ar_valid_d = load || (ar_valid_q && !ar_ready);
        ar_addr_d  = load ? head[AW-1:0] : ar_addr_q;
        ar_len_d   = load ? head[EW-1:AW] : ar_len_q;
        ar_id_d    = load ? win : ar_id_q;
        for (int i = 0; i < NCH; i++) begin
            pop[i]    = load && (win == IDW'(i));
            wptr_d[i] = wptr_q[i] + PW'(push[i]);
            rptr_d[i] = rptr_q[i] + PW'(pop[i]);
        end
    end

    // Unknown ids are sunk with r_ready high; a last beat for an idle channel flags but never wraps the count.
    always_comb begin
        rid_ok       = 1'b0;
        r_ready      = 1'b1;
        ch_rsp_valid = '0;
        for (int i = 0; i < NCH; i++) begin
            if (r_id == IDW'(i)) begin
                rid_ok          = 1'b1;
                r_ready         = ch_rsp_ready[i];
                ch_rsp_valid[i] = r_valid;
            end
        end
        r_hs   = r_valid && r_ready;
        err_d  = err_q || (r_valid && !rid_ok);
        cnt_nz = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (ar_hs && (ar_id_q == IDW'(i)))
                cnt_d[i] = cnt_d[i] + 8'd1;
            if (r_hs && r_last && (r_id == IDW'(i))) begin
                if (cnt_q[i] == 8'd0)
                    err_d = 1'b1;
                else
                    cnt_d[i] = cnt_d[i] - 8'd1;
            end
            cnt_nz = cnt_nz || (cnt_q[i] != 8'd0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                wptr_q[i] <= '0;
                rptr_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            rr_q       <= '0;
            ar_valid_q <= 1'b0;
            ar_addr_q  <= '0;
            ar_len_q   <= '0;
            ar_id_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                wptr_q[i] <= wptr_d[i];
                rptr_q[i] <= rptr_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
            rr_q       <= rr_d;
            ar_valid_q <= ar_valid_d;
            ar_addr_q  <= ar_addr_d;
            ar_len_q   <= ar_len_d;
            ar_id_q    <= ar_id_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NCH; i++)
            if (push[i])
                mem_q[i][wptr_q[i][PW-2:0]] <= {ch_req_len[i*8 +: 8], ch_req_addr[i*AW +: AW]};
    end

    assign ch_req_ready = ~full;
    assign ar_valid     = ar_valid_q;
    assign ar_addr      = ar_addr_q;
    assign ar_len       = ar_len_q;
    assign ar_id        = ar_id_q;
    assign ch_rsp_data  = r_data;
    assign ch_rsp_last  = r_last;
    assign err_rid      = err_q;
    assign busy         = !(&empty) || ar_valid_q || cnt_nz;
endmodule
